// File: rtl/slave_mux_apb3_slave.sv
// APB3 slave selector: one-hot PSEL decode, response routing from the addressed slave,
// out-of-range error response, stall watchdog and a saturating error counter.
module slave_mux_apb3_slave #(
  parameter int SELECTOR_BITS  = 4,
  parameter int DATA_BITS      = 8,
  parameter int SLAVES         = 2**SELECTOR_BITS,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ERR_CNT_BITS   = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [SELECTOR_BITS-1:0]    select,
  input  logic                        PSEL,
  input  logic                        PENABLE,
  output logic                        PREADY,
  output logic                        PSLVERR,
  output logic [DATA_BITS-1:0]        PRDATA,
  output logic [SLAVES-1:0]           PSELs,
  input  logic [SLAVES-1:0]           PREADYs,
  input  logic [SLAVES-1:0]           PSLVERRs,
  input  logic [SLAVES*DATA_BITS-1:0] PRDATAs,
  output logic [ERR_CNT_BITS-1:0]     err_count,
  input  logic                        err_clear
);

  localparam int WCW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WCW-1:0] WAIT_MAX = (TIMEOUT_CYCLES > 0) ? WCW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [ERR_CNT_BITS-1:0] ERR_MAX = '1;

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t                  r_state;
  logic [SELECTOR_BITS-1:0] r_sel_q;
  logic [WCW-1:0]          r_wait_cnt;
  logic [ERR_CNT_BITS-1:0] r_err_count;

  logic [SELECTOR_BITS-1:0] w_cur_sel;
  logic                     w_in_range;
  logic                     w_access;
  logic                     w_slv_rdy;
  logic                     w_slv_err;
  logic [DATA_BITS-1:0]     w_slv_data;
  logic                     w_timeout;

  always_comb begin
    w_cur_sel  = (r_state == S_ACCESS) ? r_sel_q : select;
    w_in_range = (int'(w_cur_sel) < SLAVES);
    w_access   = (r_state == S_ACCESS) && PSEL && PENABLE;
    w_slv_rdy  = 1'b0;
    w_slv_err  = 1'b0;
    w_slv_data = '0;
    for (int i = 0; i < SLAVES; i++) begin
      if (int'(r_sel_q) == i) begin
        w_slv_rdy  = PREADYs[i];
        w_slv_err  = PSLVERRs[i];
        w_slv_data = PRDATAs[i*DATA_BITS +: DATA_BITS];
      end
    end
    w_timeout = (TIMEOUT_CYCLES > 0) && (r_wait_cnt == WAIT_MAX) && !w_slv_rdy;
  end

  // A missing setup phase (PENABLE already high in IDLE) selects nobody.
  always_comb begin
    PSELs = '0;
    for (int i = 0; i < SLAVES; i++) begin
      PSELs[i] = PSEL && !((r_state == S_IDLE) && PENABLE) && (int'(w_cur_sel) == i);
    end
  end

  // Slave ready takes precedence over the watchdog on the same cycle.
  always_comb begin
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    PRDATA  = '0;
    if (w_access) begin
      if (!w_in_range) begin
        PREADY  = 1'b1;
        PSLVERR = 1'b1;
      end else if (w_slv_rdy) begin
        PREADY  = 1'b1;
        PSLVERR = w_slv_err;
        PRDATA  = w_slv_data;
      end else if (w_timeout) begin
        PREADY  = 1'b1;
        PSLVERR = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_sel_q     <= '0;
      r_wait_cnt  <= '0;
      r_err_count <= '0;
    end else begin
      if (r_state == S_IDLE) begin
        if (PSEL && !PENABLE) begin
          r_state    <= S_ACCESS;
          r_sel_q    <= select;
          r_wait_cnt <= '0;
        end
      end else begin
        if (!PSEL || PREADY) begin
          r_state <= S_IDLE;
        end else if (r_wait_cnt != WAIT_MAX) begin
          r_wait_cnt <= r_wait_cnt + 1'b1;
        end
      end
      if (err_clear) begin
        r_err_count <= '0;
      end else if (PREADY && PSLVERR && (r_err_count != ERR_MAX)) begin
        r_err_count <= r_err_count + 1'b1;
      end
    end
  end

  assign err_count = r_err_count;

endmodule
